// File: rtl/orv_if_realign_pkg.sv
// Shared packages for the instruction-fetch realigner.
//   orv_cfg     : width configuration (virtual address width).
//   orv_typedef : vaddr_t, inst_t, excp_cause_t and the realigner state enum.
//   orv_func    : is_rvc() halfword classifier.
// No ports; compiled ahead of every module that imports these packages.

package orv_cfg;
  localparam int VADDR_W = 32;
  localparam int INST_W  = 32;
  localparam int CAUSE_W = 4;
endpackage

package orv_typedef;
  import orv_cfg::*;

  typedef logic [VADDR_W-1:0] vaddr_t;
  typedef logic [INST_W-1:0]  inst_t;

  typedef enum logic [CAUSE_W-1:0] {
    INST_ADDR_MISALIGNED = 4'd0,
    INST_ACCESS_FAULT    = 4'd1,
    ILLEGAL_INST         = 4'd2,
    BREAKPOINT           = 4'd3,
    INST_PAGE_FAULT      = 4'd12
  } excp_cause_t;

  typedef enum logic [1:0] {
    ST_EMPTY      = 2'd0,
    ST_HALF       = 2'd1,
    ST_WAIT_FLUSH = 2'd2
  } realign_state_e;
endpackage

package orv_func;
  // A halfword opens a compressed instruction unless its low two bits are 11.
  function automatic logic is_rvc(input logic [15:0] h);
    return h[1:0] != 2'b11;
  endfunction
endpackage

// File: rtl/orv_if_realign.sv
// orv_if_realign -- splits 4-byte-aligned fetch words into a stream of
// 16-bit (RVC, zero-extended) and 32-bit instructions, handling
// instructions that straddle two fetch words.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   flush, flush_pc               redirect; flush_pc[1] selects start halfword
//   in_valid/in_ready             fetch-word handshake
//   in_word, in_pc                aligned fetch word and its address
//   in_excp_valid/in_excp_cause   fetch fault attached to in_word
//   out_valid/out_ready           instruction handshake towards decode
//   out_inst, out_pc, out_is_rvc  instruction, its address, compressed flag
//   out_excp_valid/out_excp_cause fault attributed to out_pc
//
// state         | meaning
// --------------+---------------------------------------------------------
// ST_EMPTY      | no leftover halfword; next word starts a new instruction
// ST_HALF       | upper halfword of the previous word held in r_lo_half
// ST_WAIT_FLUSH | fault emitted; words are swallowed until a flush

module orv_if_realign
  import orv_cfg::*;
  import orv_typedef::*;
  import orv_func::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  vaddr_t      flush_pc,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  input  vaddr_t      in_pc,
  input  logic        in_excp_valid,
  input  excp_cause_t in_excp_cause,
  output logic        out_valid,
  input  logic        out_ready,
  output inst_t       out_inst,
  output vaddr_t      out_pc,
  output logic        out_is_rvc,
  output logic        out_excp_valid,
  output excp_cause_t out_excp_cause
);

  realign_state_e r_state, w_state_nxt;
  logic           r_skip_lo, w_skip_lo_nxt;
  logic [15:0]    r_lo_half, w_lo_half_nxt;
  vaddr_t         r_lo_pc, w_lo_pc_nxt;

  logic           r_out_valid;
  inst_t          r_out_inst;
  vaddr_t         r_out_pc;
  logic           r_out_is_rvc;
  logic           r_out_excp_valid;
  excp_cause_t    r_out_excp_cause;

  logic           w_advance;
  logic           w_in_ready;
  logic           w_emit;
  inst_t          w_emit_inst;
  vaddr_t         w_emit_pc;
  logic           w_emit_rvc;
  logic           w_emit_excp;
  excp_cause_t    w_emit_cause;
  vaddr_t         w_in_pc_hi;

  // The output register only moves when its current content is gone.
  assign w_advance  = !r_out_valid || out_ready;
  assign w_in_pc_hi = in_pc + vaddr_t'(2);

  always_comb begin
    w_state_nxt   = r_state;
    w_skip_lo_nxt = r_skip_lo;
    w_lo_half_nxt = r_lo_half;
    w_lo_pc_nxt   = r_lo_pc;
    w_in_ready    = 1'b0;
    w_emit        = 1'b0;
    w_emit_inst   = '0;
    w_emit_pc     = '0;
    w_emit_rvc    = 1'b0;
    w_emit_excp   = 1'b0;
    w_emit_cause  = INST_ADDR_MISALIGNED;

    if (flush) begin
      w_state_nxt   = ST_EMPTY;
      w_skip_lo_nxt = flush_pc[1];
      w_lo_half_nxt = '0;
      w_lo_pc_nxt   = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          w_in_ready = w_advance;
          if (in_valid && w_advance) begin
            if (in_excp_valid) begin
              // Fault is reported at the first halfword the program wanted.
              w_emit        = 1'b1;
              w_emit_excp   = 1'b1;
              w_emit_cause  = in_excp_cause;
              w_emit_pc     = r_skip_lo ? w_in_pc_hi : in_pc;
              w_skip_lo_nxt = 1'b0;
              w_state_nxt   = ST_WAIT_FLUSH;
            end else if (r_skip_lo) begin
              w_lo_half_nxt = in_word[31:16];
              w_lo_pc_nxt   = w_in_pc_hi;
              w_skip_lo_nxt = 1'b0;
              w_state_nxt   = ST_HALF;
            end else if (!is_rvc(in_word[15:0])) begin
              w_emit      = 1'b1;
              w_emit_inst = in_word;
              w_emit_pc   = in_pc;
            end else begin
              w_emit        = 1'b1;
              w_emit_inst   = {16'h0000, in_word[15:0]};
              w_emit_pc     = in_pc;
              w_emit_rvc    = 1'b1;
              w_lo_half_nxt = in_word[31:16];
              w_lo_pc_nxt   = w_in_pc_hi;
              w_state_nxt   = ST_HALF;
            end
          end
        end

        ST_HALF: begin
          if (is_rvc(r_lo_half)) begin
            // Drain the compressed leftover without taking a word, so a
            // fault on the next word can never overtake it.
            if (w_advance) begin
              w_emit        = 1'b1;
              w_emit_inst   = {16'h0000, r_lo_half};
              w_emit_pc     = r_lo_pc;
              w_emit_rvc    = 1'b1;
              w_lo_half_nxt = '0;
              w_lo_pc_nxt   = '0;
              w_state_nxt   = ST_EMPTY;
            end
          end else begin
            w_in_ready = w_advance;
            if (in_valid && w_advance) begin
              w_emit    = 1'b1;
              w_emit_pc = r_lo_pc;
              if (in_excp_valid) begin
                w_emit_excp   = 1'b1;
                w_emit_cause  = in_excp_cause;
                w_lo_half_nxt = '0;
                w_lo_pc_nxt   = '0;
                w_state_nxt   = ST_WAIT_FLUSH;
              end else begin
                w_emit_inst   = {in_word[15:0], r_lo_half};
                w_lo_half_nxt = in_word[31:16];
                w_lo_pc_nxt   = w_in_pc_hi;
              end
            end
          end
        end

        ST_WAIT_FLUSH: begin
          w_in_ready = 1'b1;
        end

        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_EMPTY;
      r_skip_lo <= 1'b0;
      r_lo_half <= '0;
      r_lo_pc   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_skip_lo <= w_skip_lo_nxt;
      r_lo_half <= w_lo_half_nxt;
      r_lo_pc   <= w_lo_pc_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid      <= 1'b0;
      r_out_inst       <= '0;
      r_out_pc         <= '0;
      r_out_is_rvc     <= 1'b0;
      r_out_excp_valid <= 1'b0;
      r_out_excp_cause <= INST_ADDR_MISALIGNED;
    end else if (flush) begin
      r_out_valid      <= 1'b0;
      r_out_excp_valid <= 1'b0;
    end else if (w_advance) begin
      r_out_valid      <= w_emit;
      r_out_inst       <= w_emit_inst;
      r_out_pc         <= w_emit_pc;
      r_out_is_rvc     <= w_emit_rvc;
      r_out_excp_valid <= w_emit_excp;
      r_out_excp_cause <= w_emit_cause;
    end
  end

  assign in_ready       = w_in_ready;
  assign out_valid      = r_out_valid;
  assign out_inst       = r_out_inst;
  assign out_pc         = r_out_pc;
  assign out_is_rvc     = r_out_is_rvc;
  assign out_excp_valid = r_out_excp_valid;
  assign out_excp_cause = r_out_excp_cause;

endmodule

// File: tb/tb_orv_if_realign.sv
// Directed testbench for orv_if_realign: hand-computed instruction streams
// covering splitting, straddling, redirect, faults, back-pressure and reset.

module tb_orv_if_realign;
  import orv_cfg::*;
  import orv_typedef::*;

  logic        clk;
  logic        rst;
  logic        flush;
  vaddr_t      flush_pc;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  vaddr_t      in_pc;
  logic        in_excp_valid;
  excp_cause_t in_excp_cause;
  logic        out_valid;
  logic        out_ready;
  inst_t       out_inst;
  vaddr_t      out_pc;
  logic        out_is_rvc;
  logic        out_excp_valid;
  excp_cause_t out_excp_cause;

  int n_cmp;
  int n_bad;

  orv_if_realign dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_word        (in_word),
    .in_pc          (in_pc),
    .in_excp_valid  (in_excp_valid),
    .in_excp_cause  (in_excp_cause),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_is_rvc     (out_is_rvc),
    .out_excp_valid (out_excp_valid),
    .out_excp_cause (out_excp_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input vaddr_t pc,
                       input logic ex, input excp_cause_t cause);
    in_valid      = v;
    in_word       = w;
    in_pc         = pc;
    in_excp_valid = ex;
    in_excp_cause = cause;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, '0, 1'b0, INST_ADDR_MISALIGNED);
  endtask

  task automatic check_out(input string tag, input logic [31:0] inst,
                           input vaddr_t pc, input logic rvc);
    chk({tag, ".valid"}, 64'(out_valid), 64'(1'b1));
    chk({tag, ".inst"},  64'(out_inst),  64'(inst));
    chk({tag, ".pc"},    64'(out_pc),    64'(pc));
    chk({tag, ".rvc"},   64'(out_is_rvc), 64'(rvc));
    chk({tag, ".excp"},  64'(out_excp_valid), 64'(1'b0));
  endtask

  task automatic do_flush(input vaddr_t pc);
    flush    = 1'b1;
    flush_pc = pc;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'(1'b0));
    tick();
    flush = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'(1'b0));
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    flush_pc  = '0;
    out_ready = 1'b1;
    idle();
    tick();
    tick();

    // reset values
    chk("rst.out_valid", 64'(out_valid), 64'(1'b0));
    chk("rst.out_excp",  64'(out_excp_valid), 64'(1'b0));
    chk("rst.out_inst",  64'(out_inst), 64'(0));
    chk("rst.out_pc",    64'(out_pc), 64'(0));
    chk("rst.out_rvc",   64'(out_is_rvc), 64'(0));
    rst = 1'b0;

    // two compressed halves in one word; the second is drained with in_ready low
    drive(1'b1, 32'h4501_4505, 32'h8000_0000, 1'b0, INST_ADDR_MISALIGNED);
    #1;
    chk("rvc2.in_ready0", 64'(in_ready), 64'(1'b1));
    tick();
    check_out("rvc2.a", 32'h0000_4505, 32'h8000_0000, 1'b1);
    drive(1'b1, 32'h0000_0013, 32'h8000_0004, 1'b0, INST_ADDR_MISALIGNED);
    #1;
    chk("rvc2.in_ready1", 64'(in_ready), 64'(1'b0));
    tick();
    check_out("rvc2.b", 32'h0000_4501, 32'h8000_0002, 1'b1);
    tick();
    check_out("full32", 32'h0000_0013, 32'h8000_0004, 1'b0);
    idle();
    tick();
    chk("full32.drain", 64'(out_valid), 64'(1'b0));

    // 32-bit instruction straddling two words
    drive(1'b1, 32'h0513_4505, 32'h8000_0000, 1'b0, INST_ADDR_MISALIGNED);
    tick();
    check_out("strad.a", 32'h0000_4505, 32'h8000_0000, 1'b1);
    drive(1'b1, 32'h4501_0010, 32'h8000_0004, 1'b0, INST_ADDR_MISALIGNED);
    #1;
    chk("strad.in_ready", 64'(in_ready), 64'(1'b1));
    tick();
    check_out("strad.b", 32'h0010_0513, 32'h8000_0002, 1'b0);
    idle();
    tick();
    check_out("strad.c", 32'h0000_4501, 32'h8000_0006, 1'b1);
    tick();
    chk("strad.drain", 64'(out_valid), 64'(1'b0));

    // redirect into the upper halfword; low half is dropped
    do_flush(32'h8000_0102);
    drive(1'b1, 32'h4505_ABCD, 32'h8000_0100, 1'b0, INST_ADDR_MISALIGNED);
    tick();
    chk("skip.none", 64'(out_valid), 64'(1'b0));
    idle();
    tick();
    check_out("skip.hi", 32'h0000_4505, 32'h8000_0102, 1'b1);
    tick();
    chk("skip.single", 64'(out_valid), 64'(1'b0));

    // fault on the word completing a straddled instruction
    drive(1'b1, 32'h0513_4505, 32'h8000_0000, 1'b0, INST_ADDR_MISALIGNED);
    tick();
    check_out("flt.a", 32'h0000_4505, 32'h8000_0000, 1'b1);
    drive(1'b1, 32'h1234_5678, 32'h8000_0004, 1'b1, INST_PAGE_FAULT);
    tick();
    chk("flt.valid", 64'(out_valid), 64'(1'b1));
    chk("flt.excp",  64'(out_excp_valid), 64'(1'b1));
    chk("flt.pc",    64'(out_pc), 64'(32'h8000_0002));
    chk("flt.inst",  64'(out_inst), 64'(0));
    chk("flt.cause", 64'(out_excp_cause), 64'(INST_PAGE_FAULT));
    drive(1'b1, 32'h0000_0013, 32'h8000_0008, 1'b0, INST_ADDR_MISALIGNED);
    #1;
    chk("flt.in_ready", 64'(in_ready), 64'(1'b1));
    tick();
    chk("flt.discard0", 64'(out_valid), 64'(1'b0));
    tick();
    chk("flt.discard1", 64'(out_valid), 64'(1'b0));
    idle();
    do_flush(32'h8000_0200);

    // back-pressure: output held for three cycles, then released
    out_ready = 1'b0;
    drive(1'b1, 32'h0513_4505, 32'h8000_0200, 1'b0, INST_ADDR_MISALIGNED);
    tick();
    check_out("stall.a", 32'h0000_4505, 32'h8000_0200, 1'b1);
    drive(1'b1, 32'h4501_0010, 32'h8000_0204, 1'b0, INST_ADDR_MISALIGNED);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("stall.hold", 32'h0000_4505, 32'h8000_0200, 1'b1);
      chk("stall.in_ready", 64'(in_ready), 64'(1'b0));
    end
    out_ready = 1'b1;
    tick();
    check_out("stall.b", 32'h0010_0513, 32'h8000_0202, 1'b0);
    // flush while output is pending and a compressed leftover is held
    idle();
    out_ready = 1'b0;
    do_flush(32'h8000_0300);
    out_ready = 1'b1;
    tick();
    chk("fl_half.gone0", 64'(out_valid), 64'(1'b0));
    tick();
    chk("fl_half.gone1", 64'(out_valid), 64'(1'b0));

    // asynchronous reset mid-operation drops output and leftover
    drive(1'b1, 32'h4501_4505, 32'h8000_0400, 1'b0, INST_ADDR_MISALIGNED);
    tick();
    check_out("arst.a", 32'h0000_4505, 32'h8000_0400, 1'b1);
    idle();
    rst = 1'b1;
    #1;
    chk("arst.now", 64'(out_valid), 64'(1'b0));
    #2;
    rst = 1'b0;
    tick();
    chk("arst.left0", 64'(out_valid), 64'(1'b0));
    tick();
    chk("arst.left1", 64'(out_valid), 64'(1'b0));

    // fault on a skipped-low word is reported at the upper halfword
    do_flush(32'h8000_0502);
    drive(1'b1, 32'hFFFF_FFFF, 32'h8000_0500, 1'b1, INST_ACCESS_FAULT);
    tick();
    chk("skflt.excp",  64'(out_excp_valid), 64'(1'b1));
    chk("skflt.pc",    64'(out_pc), 64'(32'h8000_0502));
    chk("skflt.cause", 64'(out_excp_cause), 64'(INST_ACCESS_FAULT));
    idle();

    // top of the address space
    do_flush(32'hFFFF_FFFC);
    drive(1'b1, 32'h4501_4505, 32'hFFFF_FFFC, 1'b0, INST_ADDR_MISALIGNED);
    tick();
    check_out("top.a", 32'h0000_4505, 32'hFFFF_FFFC, 1'b1);
    idle();
    tick();
    check_out("top.b", 32'h0000_4501, 32'hFFFF_FFFE, 1'b1);
    tick();
    chk("top.drain", 64'(out_valid), 64'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
